// File: rtl/cp0_int_timer.sv
// CP0 status/interrupt controller: BadVAddr, Count, Compare, Status, Cause, EPC,
// hardware interrupt synchroniser and Count/Compare timer.
module cp0_int_timer (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_rdata,
    input  logic [5:0]  hw_int,
    input  logic        exp_we,
    input  logic        exp_clean_exl,
    input  logic [4:0]  exp_code,
    input  logic        exp_bd,
    input  logic [31:0] exp_epc,
    input  logic        exp_badv_we,
    input  logic [31:0] exp_bad_vaddr,
    output logic [7:0]  interrupt_flags,
    output logic        allow_int,
    output logic [31:0] epc_out,
    output logic        timer_int
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic        bd_q,       bd_d;
    logic        ti_q,       ti_d;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q,      epc_d;
    logic        tick_q,     tick_d;
    logic [5:0]  s1_q,       s1_d;
    logic [5:0]  hw_s_q,     hw_s_d;

    logic        mtc0_en_s;
    logic        inc_s;
    logic [31:0] count_inc_s;
    logic [7:0]  ip_s;
    logic [31:0] status_s;
    logic [31:0] cause_s;

    // A committing exception or ERET flushes the MTC0 in flight.
    assign mtc0_en_s   = mtc0_we & ~exp_we & ~exp_clean_exl;
    assign inc_s       = tick_q & ~(mtc0_en_s && (mtc0_addr == REG_COUNT));
    assign count_inc_s = count_q + 32'd1;

    assign ip_s     = {hw_s_q[5] | ti_q, hw_s_q[4:0], ip_sw_q};
    assign status_s = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_s  = {bd_q, ti_q, 14'd0, ip_s, 1'b0, exc_code_q, 2'd0};

    assign interrupt_flags = ip_s & im_q;
    assign allow_int       = ie_q & ~exl_q;
    assign epc_out         = epc_q;
    assign timer_int       = ti_q;

    // Next-state logic for every architectural register.
    always_comb begin
        s1_d   = hw_int;
        hw_s_d = s1_q;

        if (mtc0_en_s && (mtc0_addr == REG_COUNT)) begin
            count_d = mtc0_wdata;
            tick_d  = 1'b0;
        end else begin
            count_d = inc_s ? count_inc_s : count_q;
            tick_d  = ~tick_q;
        end

        compare_d = (mtc0_en_s && (mtc0_addr == REG_COMPARE)) ? mtc0_wdata : compare_q;

        // Writing Compare acknowledges the timer and wins over a same-cycle match.
        if (mtc0_en_s && (mtc0_addr == REG_COMPARE)) begin
            ti_d = 1'b0;
        end else if (inc_s && (count_inc_s == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end

        if (mtc0_en_s && (mtc0_addr == REG_STATUS)) begin
            im_d = mtc0_wdata[15:8];
            ie_d = mtc0_wdata[0];
        end else begin
            im_d = im_q;
            ie_d = ie_q;
        end

        if (exp_we) begin
            exl_d = 1'b1;
        end else if (exp_clean_exl) begin
            exl_d = 1'b0;
        end else if (mtc0_en_s && (mtc0_addr == REG_STATUS)) begin
            exl_d = mtc0_wdata[1];
        end else begin
            exl_d = exl_q;
        end

        // A nested exception keeps the original EPC/BD.
        if (exp_we && !exl_q) begin
            epc_d = exp_epc;
            bd_d  = exp_bd;
        end else if (mtc0_en_s && (mtc0_addr == REG_EPC)) begin
            epc_d = mtc0_wdata;
            bd_d  = bd_q;
        end else begin
            epc_d = epc_q;
            bd_d  = bd_q;
        end

        exc_code_d = exp_we ? exp_code : exc_code_q;
        badvaddr_d = (exp_we && exp_badv_we) ? exp_bad_vaddr : badvaddr_q;
        ip_sw_d    = (mtc0_en_s && (mtc0_addr == REG_CAUSE)) ? mtc0_wdata[9:8] : ip_sw_q;
    end

    // MFC0 read multiplexer.
    always_comb begin
        case (mfc0_addr)
            REG_BADVADDR: mfc0_rdata = badvaddr_q;
            REG_COUNT:    mfc0_rdata = count_q;
            REG_COMPARE:  mfc0_rdata = compare_q;
            REG_STATUS:   mfc0_rdata = status_s;
            REG_CAUSE:    mfc0_rdata = cause_s;
            REG_EPC:      mfc0_rdata = epc_q;
            default:      mfc0_rdata = 32'd0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            tick_q     <= 1'b0;
            s1_q       <= 6'd0;
            hw_s_q     <= 6'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            tick_q     <= tick_d;
            s1_q       <= s1_d;
            hw_s_q     <= hw_s_d;
        end
    end

endmodule

// File: tb/tb_cp0_int_timer.sv
// Self-checking bench for cp0_int_timer: directed scenarios plus a randomized
// timer/interrupt run against an arithmetic reference model.
module tb_cp0_int_timer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic [5:0]  hw_int;
    logic        exp_we;
    logic        exp_clean_exl;
    logic [4:0]  exp_code;
    logic        exp_bd;
    logic [31:0] exp_epc;
    logic        exp_badv_we;
    logic [31:0] exp_bad_vaddr;
    logic [7:0]  interrupt_flags;
    logic        allow_int;
    logic [31:0] epc_out;
    logic        timer_int;

    int checks = 0;
    int errors = 0;

    cp0_int_timer dut (
        .aclk(aclk), .aresetn(aresetn),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .hw_int(hw_int),
        .exp_we(exp_we), .exp_clean_exl(exp_clean_exl), .exp_code(exp_code),
        .exp_bd(exp_bd), .exp_epc(exp_epc),
        .exp_badv_we(exp_badv_we), .exp_bad_vaddr(exp_bad_vaddr),
        .interrupt_flags(interrupt_flags), .allow_int(allow_int),
        .epc_out(epc_out), .timer_int(timer_int)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
        step();
        mtc0_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        mfc0_addr = a;
        #1;
        d = mfc0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        aresetn = 1'b0;
        step(); step();
        rd(5'd12, v); checks++;
        if (v !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h0040_0000); end
        rd(5'd13, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 0", v); end
        rd(5'd14, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", v); end
        rd(5'd9, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", v); end
        rd(5'd5, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_unimpl: got %h expected 0", v); end
        checks++;
        if ({interrupt_flags, allow_int, timer_int, epc_out} !== 42'd0) begin
            errors++; $display("FAIL reset_outputs: got flags=%h allow=%b ti=%b epc=%h expected all 0",
                               interrupt_flags, allow_int, timer_int, epc_out);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_timer();
        logic [31:0] v;
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        checks++;
        if (allow_int !== 1'b1) begin errors++; $display("FAIL timer_allow: got %b expected 1", allow_int); end
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) step();
            rd(5'd9, v); checks++;
            if (v !== 32'(k / 2)) begin errors++; $display("FAIL timer_count k=%0d: got %h expected %h", k, v, 32'(k / 2)); end
            checks++;
            if (timer_int !== (k >= 10)) begin errors++; $display("FAIL timer_ti k=%0d: got %b expected %b", k, timer_int, (k >= 10)); end
            checks++;
            if (interrupt_flags !== ((k >= 10) ? 8'h80 : 8'h00)) begin
                errors++; $display("FAIL timer_flags k=%0d: got %h expected %h", k, interrupt_flags, ((k >= 10) ? 8'h80 : 8'h00));
            end
        end
        mtc0(5'd11, 32'd100);
        checks++;
        if (timer_int !== 1'b0 || interrupt_flags !== 8'h00) begin
            errors++; $display("FAIL timer_clear: got ti=%b flags=%h expected 0/00", timer_int, interrupt_flags);
        end
    endtask

    task automatic test_hw_int();
        logic [31:0] v;
        mtc0(5'd11, 32'h8000_0000);
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'h01;
        step(); checks++;
        if (interrupt_flags !== 8'h00) begin errors++; $display("FAIL hw_early: got %h expected 00", interrupt_flags); end
        step(); checks++;
        if (interrupt_flags !== 8'h04) begin errors++; $display("FAIL hw_set: got %h expected 04", interrupt_flags); end
        rd(5'd13, v); checks++;
        if (v !== 32'h0000_0400) begin errors++; $display("FAIL hw_cause: got %h expected %h", v, 32'h0000_0400); end
        hw_int = 6'h00;
        step(); checks++;
        if (interrupt_flags !== 8'h04) begin errors++; $display("FAIL hw_hold: got %h expected 04", interrupt_flags); end
        step(); checks++;
        if (interrupt_flags !== 8'h00) begin errors++; $display("FAIL hw_clear: got %h expected 00", interrupt_flags); end
    endtask

    task automatic test_exception();
        logic [31:0] v;
        exp_we = 1'b1; exp_epc = 32'hBFC0_0100; exp_bd = 1'b1; exp_code = 5'h0C;
        exp_badv_we = 1'b1; exp_bad_vaddr = 32'h1234_5671;
        step();
        exp_we = 1'b0; exp_badv_we = 1'b0;
        rd(5'd14, v); checks++;
        if (v !== 32'hBFC0_0100 || epc_out !== 32'hBFC0_0100) begin
            errors++; $display("FAIL exc_epc: got %h/%h expected %h", v, epc_out, 32'hBFC0_0100);
        end
        rd(5'd13, v); checks++;
        if (v !== 32'h8000_0030) begin errors++; $display("FAIL exc_cause: got %h expected %h", v, 32'h8000_0030); end
        rd(5'd12, v); checks++;
        if (v !== 32'h0040_0403 || allow_int !== 1'b0) begin
            errors++; $display("FAIL exc_status: got %h allow=%b expected %h allow=0", v, allow_int, 32'h0040_0403);
        end
        rd(5'd8, v); checks++;
        if (v !== 32'h1234_5671) begin errors++; $display("FAIL exc_badv: got %h expected %h", v, 32'h1234_5671); end
        exp_we = 1'b1; exp_epc = 32'h1111_0000; exp_bd = 1'b0; exp_code = 5'h04;
        exp_bad_vaddr = 32'hDEAD_BEEF;
        step();
        exp_we = 1'b0;
        rd(5'd14, v); checks++;
        if (v !== 32'hBFC0_0100) begin errors++; $display("FAIL nested_epc: got %h expected %h", v, 32'hBFC0_0100); end
        rd(5'd13, v); checks++;
        if (v !== 32'h8000_0010) begin errors++; $display("FAIL nested_cause: got %h expected %h", v, 32'h8000_0010); end
        rd(5'd8, v); checks++;
        if (v !== 32'h1234_5671) begin errors++; $display("FAIL nested_badv: got %h expected %h", v, 32'h1234_5671); end
    endtask

    task automatic test_eret_collision();
        logic [31:0] v;
        exp_clean_exl = 1'b1;
        mtc0(5'd12, 32'h0000_0000);
        exp_clean_exl = 1'b0;
        rd(5'd12, v); checks++;
        if (v !== 32'h0040_0401) begin errors++; $display("FAIL eret_status: got %h expected %h", v, 32'h0040_0401); end
        checks++;
        if (allow_int !== 1'b1) begin errors++; $display("FAIL eret_allow: got %b expected 1", allow_int); end
    endtask

    task automatic test_sw_int();
        logic [31:0] v;
        mtc0(5'd12, 32'h0000_0301);
        mtc0(5'd13, 32'hFFFF_FFFF & 32'h0000_0300);
        checks++;
        if (interrupt_flags !== 8'h03) begin errors++; $display("FAIL sw_flags: got %h expected 03", interrupt_flags); end
        rd(5'd13, v); checks++;
        if (v !== 32'h8000_0310) begin errors++; $display("FAIL sw_cause: got %h expected %h", v, 32'h8000_0310); end
        mtc0(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unimpl_write: got %h expected 0", v); end
        mtc0(5'd14, 32'hA5A5_0004);
        checks++;
        if (epc_out !== 32'hA5A5_0004) begin errors++; $display("FAIL mtc0_epc: got %h expected %h", epc_out, 32'hA5A5_0004); end
    endtask

    // Reference: after a Count load at edge 0, edge k leaves Count = base + k/2,
    // and TI rises on the first even k whose count equals Compare.
    // hw_int driven before edge i is visible on the flags after edge i+1.
    task automatic test_random_timer();
        logic [31:0] base, cmp, cnt, v;
        logic [5:0]  prev, r;
        logic        ti;
        logic [7:0]  exp_flags;
        mtc0(5'd12, 32'h0000_FF01);
        mtc0(5'd13, 32'h0000_0000);
        for (int t = 0; t < 8; t++) begin
            base = (t % 2 == 1) ? $urandom : (32'hFFFF_FFFF - 32'($urandom_range(0, 4)));
            cmp  = base + 32'($urandom_range(0, 8));
            mtc0(5'd11, cmp);
            mtc0(5'd9, base);
            prev = 6'd0;
            ti   = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                r = 6'($urandom_range(0, 63));
                hw_int = r;
                step();
                cnt = base + 32'(k / 2);
                if ((k % 2 == 0) && (cnt == cmp)) ti = 1'b1;
                exp_flags = {prev[5] | ti, prev[4:0], 2'b00};
                prev = r;
                rd(5'd9, v); checks++;
                if (v !== cnt) begin errors++; $display("FAIL rnd_count t=%0d k=%0d: got %h expected %h", t, k, v, cnt); end
                checks++;
                if (timer_int !== ti) begin errors++; $display("FAIL rnd_ti t=%0d k=%0d: got %b expected %b", t, k, timer_int, ti); end
                checks++;
                if (interrupt_flags !== exp_flags) begin
                    errors++; $display("FAIL rnd_flags t=%0d k=%0d: got %h expected %h", t, k, interrupt_flags, exp_flags);
                end
            end
            hw_int = 6'd0;
        end
    endtask

    task automatic test_count_wrap();
        logic [31:0] v;
        mtc0(5'd11, 32'h0000_0000);
        mtc0(5'd9, 32'hFFFF_FFFE);
        step(); step(); step();
        rd(5'd9, v); checks++;
        if (v !== 32'hFFFF_FFFF || timer_int !== 1'b0) begin
            errors++; $display("FAIL wrap_pre: got %h ti=%b expected ffffffff ti=0", v, timer_int);
        end
        step();
        rd(5'd9, v); checks++;
        if (v !== 32'h0 || timer_int !== 1'b1) begin
            errors++; $display("FAIL wrap_match: got %h ti=%b expected 0 ti=1", v, timer_int);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        hw_int = 6'h3F;
        step(); step();
        hw_int = 6'h00;
        aresetn = 1'b0;
        step();
        checks++;
        if ({interrupt_flags, allow_int, timer_int, epc_out} !== 42'd0) begin
            errors++; $display("FAIL midreset_outputs: got flags=%h allow=%b ti=%b epc=%h expected all 0",
                               interrupt_flags, allow_int, timer_int, epc_out);
        end
        rd(5'd12, v); checks++;
        if (v !== 32'h0040_0000) begin errors++; $display("FAIL midreset_status: got %h expected %h", v, 32'h0040_0000); end
        rd(5'd13, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_cause: got %h expected 0", v); end
        rd(5'd8, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_badv: got %h expected 0", v); end
        aresetn = 1'b1;
        step(); step();
        checks++;
        if (interrupt_flags !== 8'h00) begin errors++; $display("FAIL midreset_sync: got %h expected 00", interrupt_flags); end
    endtask

    initial begin
        aresetn = 1'b0; mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_wdata = 32'd0;
        mfc0_addr = 5'd0; hw_int = 6'd0; exp_we = 1'b0; exp_clean_exl = 1'b0;
        exp_code = 5'd0; exp_bd = 1'b0; exp_epc = 32'd0; exp_badv_we = 1'b0;
        exp_bad_vaddr = 32'd0;
        test_reset();
        test_timer();
        test_hw_int();
        test_exception();
        test_eret_collision();
        test_sw_int();
        test_random_timer();
        test_count_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
